// File: rtl/uart_deser_param.sv
// Serial-to-parallel converter for the UART receive path: gathers DATA_WIDTH
// bits in either order, optionally checks a trailing parity bit, and strobes a registered word.
module uart_deser_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

  typedef enum logic {
    S_DATA,
    S_PAR
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    valid_q, valid_d;
  logic                    par_err_q, par_err_d;
  logic                    busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DATA;
      cnt_q     <= '0;
      sh_q      <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    p_data_d  = p_data_q;
    valid_d   = 1'b0;
    par_err_d = par_err_q;

    if (clear) begin
      state_d = S_DATA;
      cnt_d   = '0;
      sh_d    = '0;
    end else if (deser_en) begin
      unique case (state_q)
        S_DATA: begin
          if (LSB_FIRST) sh_d = {sampled_bit, sh_q[DATA_WIDTH-1:1]};
          else           sh_d = {sh_q[DATA_WIDTH-2:0], sampled_bit};
          if (cnt_q == CNT_LAST) begin
            // Parity settings are captured only here, so mid-frame changes are ignored.
            par_en_d  = par_en;
            par_typ_d = par_typ;
            if (par_en_d) begin
              state_d = S_PAR;
              cnt_d   = CNT_FULL;
            end else begin
              p_data_d  = sh_d;
              valid_d   = 1'b1;
              par_err_d = 1'b0;
              cnt_d     = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PAR: begin
          par_err_d = sampled_bit ^ (^sh_q) ^ par_typ_q;
          p_data_d  = sh_q;
          valid_d   = 1'b1;
          cnt_d     = '0;
          state_d   = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign busy       = busy_q;

endmodule
